// File: rtl/intersection_controller.sv
// intersection_controller
//   Shared-phase controller for a two-way intersection (main street, side
//   street) with an optional pedestrian crossing. Main street rests on green;
//   side-street and pedestrian requests are latched and served in a fixed,
//   conflict-free phase order. Night mode flashes main yellow / side red.
//
//   Optional feature macro: PED_CROSSING_EN (pedestrian latch, walk lamp, ack).
//
// Ports
//   clk       in   clock
//   reset     in   asynchronous, active-high reset
//   day       in   1 = normal sequencing, 0 = night flash requested
//   side_req  in   side-street vehicle sensor (level)
//   ped_req   in   pedestrian button (level); ignored without PED_CROSSING_EN
//   main_r/y/g out main-street lamps
//   side_r/y/g out side-street lamps
//   ped_walk  out  walk lamp, lit during a served side-green phase
//   ped_ack   out  one-cycle pulse on the first cycle of a served walk phase
//   state_o   out  current state encoding (debug)
module intersection_controller #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GREEN_MIN  = 8,
  parameter int unsigned SIDE_GREEN = 6,
  parameter int unsigned YELLOW_T   = 3,
  parameter int unsigned ALLRED_T   = 2,
  parameter int unsigned BLINK_T    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       day,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    MAIN_G = 3'd1,
    MAIN_Y = 3'd2,
    CLR1   = 3'd3,
    SIDE_G = 3'd4,
    SIDE_Y = 3'd5,
    CLR2   = 3'd6,
    NIGHT  = 3'd7
  } state_t;

  // Last timer value of each timed phase (a phase of D cycles exits at D-1).
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_T - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic             side_pend;
  logic             ped_pend;
  logic             night_pend;
  logic             blink;
  logic             serve_req;
  logic             state_chg;
  logic             enter_side;
  logic             enter_night;

  assign state_chg   = (state_nxt != state);
  assign enter_side  = (state_nxt == SIDE_G) && (state != SIDE_G);
  assign enter_night = (state_nxt == NIGHT) && (state != NIGHT);

`ifdef PED_CROSSING_EN
  logic ped_srv;

  assign serve_req = side_pend | ped_pend;

  // Pedestrian latch: a request present on the SIDE_G entry edge is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pend <= 1'b0;
      ped_srv  <= 1'b0;
    end else begin
      if (enter_side) begin
        ped_pend <= 1'b0;
        ped_srv  <= ped_pend;
      end else if (ped_req) begin
        ped_pend <= 1'b1;
      end
    end
  end

  assign ped_walk = ped_srv && (state == SIDE_G);
  // Timer is 0 only on the first cycle of SIDE_G.
  assign ped_ack  = ped_walk && (timer == '0);
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_pend       = 1'b0;
  assign serve_req      = side_pend;
  assign ped_walk       = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:   if (timer == ALLRED_LAST) state_nxt = MAIN_G;
      MAIN_G: if (!day || (serve_req && (timer >= GREEN_LAST))) state_nxt = MAIN_Y;
      MAIN_Y: if (timer == YELLOW_LAST) state_nxt = CLR1;
      CLR1:   if (timer == ALLRED_LAST) state_nxt = night_pend ? NIGHT : SIDE_G;
      SIDE_G: if (timer == SIDE_LAST)   state_nxt = SIDE_Y;
      SIDE_Y: if (timer == YELLOW_LAST) state_nxt = CLR2;
      CLR2:   if (timer == ALLRED_LAST) state_nxt = MAIN_G;
      NIGHT:  if (day) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  // Phase timer: clears on state change and on each night half-period wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state_chg) begin
      timer <= '0;
    end else if ((state == NIGHT) && (timer == BLINK_LAST)) begin
      timer <= '0;
    end else if (timer != TIMER_MAX) begin
      timer <= timer + CNT_W'(1);
    end
  end

  // Night blink phase: starts lit on NIGHT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink <= 1'b1;
    end else if (enter_night) begin
      blink <= 1'b1;
    end else if ((state == NIGHT) && !state_chg && (timer == BLINK_LAST)) begin
      blink <= ~blink;
    end
  end

  // Night request: remembered from MAIN_G exit until NIGHT is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      night_pend <= 1'b0;
    end else if (enter_night) begin
      night_pend <= 1'b0;
    end else if ((state == MAIN_G) && state_chg && !day) begin
      night_pend <= 1'b1;
    end
  end

  // Side-street latch: a request present on the SIDE_G entry edge is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      side_pend <= 1'b0;
    end else if (enter_side) begin
      side_pend <= 1'b0;
    end else if (side_req) begin
      side_pend <= 1'b1;
    end
  end

  // Lamp decode from registered state.
  always_comb begin
    main_r = 1'b0;
    main_y = 1'b0;
    main_g = 1'b0;
    side_r = 1'b0;
    side_y = 1'b0;
    side_g = 1'b0;
    case (state)
      MAIN_G: begin main_g = 1'b1; side_r = 1'b1; end
      MAIN_Y: begin main_y = 1'b1; side_r = 1'b1; end
      SIDE_G: begin main_r = 1'b1; side_g = 1'b1; end
      SIDE_Y: begin main_r = 1'b1; side_y = 1'b1; end
      NIGHT:  begin main_y = blink; side_r = blink; end
      default: begin main_r = 1'b1; side_r = 1'b1; end
    endcase
  end

  assign state_o = 3'(state);

endmodule

// File: tb/tb_intersection_controller.sv
// tb_intersection_controller
//   Directed testbench for intersection_controller with default parameters.
//   Expected phase lengths and lamp patterns are written out by hand.
module tb_intersection_controller;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_MAIN_G = 3'd1;
  localparam logic [2:0] S_MAIN_Y = 3'd2;
  localparam logic [2:0] S_CLR1   = 3'd3;
  localparam logic [2:0] S_SIDE_G = 3'd4;
  localparam logic [2:0] S_SIDE_Y = 3'd5;
  localparam logic [2:0] S_CLR2   = 3'd6;
  localparam logic [2:0] S_NIGHT  = 3'd7;

  logic       clk;
  logic       reset;
  logic       day;
  logic       side_req;
  logic       ped_req;
  logic       main_r, main_y, main_g;
  logic       side_r, side_y, side_g;
  logic       ped_walk;
  logic       ped_ack;
  logic [2:0] state_o;
  logic [5:0] lamps;

  int  n_tests;
  int  n_fail;
  logic exp_walk;

  intersection_controller dut (
    .clk      (clk),
    .reset    (reset),
    .day      (day),
    .side_req (side_req),
    .ped_req  (ped_req),
    .main_r   (main_r),
    .main_y   (main_y),
    .main_g   (main_g),
    .side_r   (side_r),
    .side_y   (side_y),
    .side_g   (side_g),
    .ped_walk (ped_walk),
    .ped_ack  (ped_ack),
    .state_o  (state_o)
  );

  assign lamps = {main_r, main_y, main_g, side_r, side_y, side_g};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lamp pattern {main_r,main_y,main_g,side_r,side_y,side_g} for day states.
  function automatic logic [5:0] lamp_exp(input logic [2:0] s);
    case (s)
      S_MAIN_G: lamp_exp = 6'b001_100;
      S_MAIN_Y: lamp_exp = 6'b010_100;
      S_SIDE_G: lamp_exp = 6'b100_001;
      S_SIDE_Y: lamp_exp = 6'b100_010;
      default:  lamp_exp = 6'b100_100;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect state s for n consecutive cycles, starting at the current sample.
  task automatic run_state(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      check("state", 8'(state_o), 8'(s));
      check("lamps", 8'(lamps), 8'(lamp_exp(s)));
      check("walk", 8'(ped_walk), 8'(exp_walk && (s == S_SIDE_G)));
      check("ack", 8'(ped_ack), 8'(exp_walk && (s == S_SIDE_G) && (i == 0)));
      step();
    end
  endtask

  // Expect NIGHT with main_y/side_r equal to b for n cycles.
  task automatic run_night(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      check("night_state", 8'(state_o), 8'(S_NIGHT));
      check("night_lamps", 8'(lamps), 8'({1'b0, b, 1'b0, b, 1'b0, 1'b0}));
      step();
    end
  endtask

  // Full side phase from the first MAIN_Y cycle to the first MAIN_G cycle.
  task automatic side_cycle();
    run_state(S_MAIN_Y, 3);
    run_state(S_CLR1, 2);
    run_state(S_SIDE_G, 6);
    run_state(S_SIDE_Y, 3);
    run_state(S_CLR2, 2);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_walk = 1'b0;
    reset    = 1'b1;
    day      = 1'b1;
    side_req = 1'b0;
    ped_req  = 1'b0;

    // Reset values, then idle: 2 cycles all red, main green held.
    repeat (3) step();
    check("rst_state", 8'(state_o), 8'(S_INIT));
    check("rst_lamps", 8'(lamps), 8'(6'b100_100));
    check("rst_walk", 8'(ped_walk), 8'd0);
    check("rst_ack", 8'(ped_ack), 8'd0);
    reset = 1'b0;
    run_state(S_INIT, 2);
    run_state(S_MAIN_G, 200);

    // Request after minimum green elapsed: latched, then MAIN_G ends next cycle.
    side_req = 1'b1;
    run_state(S_MAIN_G, 1);
    side_req = 1'b0;
    run_state(S_MAIN_G, 1);
    side_cycle();

    // One-cycle pulse at MAIN_G timer=3: MAIN_G lasts 8 cycles total.
    run_state(S_MAIN_G, 3);
    side_req = 1'b1;
    run_state(S_MAIN_G, 1);
    side_req = 1'b0;
    run_state(S_MAIN_G, 4);
    side_cycle();

    // Held across SIDE_G entry (consumed), re-pulsed in SIDE_Y (served again).
    side_req = 1'b1;
    run_state(S_MAIN_G, 8);
    run_state(S_MAIN_Y, 3);
    run_state(S_CLR1, 2);
    side_req = 1'b0;
    run_state(S_SIDE_G, 6);
    run_state(S_SIDE_Y, 1);
    side_req = 1'b1;
    run_state(S_SIDE_Y, 1);
    side_req = 1'b0;
    run_state(S_SIDE_Y, 1);
    run_state(S_CLR2, 2);
    run_state(S_MAIN_G, 8);
    side_cycle();
    run_state(S_MAIN_G, 30);

`ifdef PED_CROSSING_EN
    // Pedestrian request alone triggers a side phase with walk and ack.
    ped_req = 1'b1;
    run_state(S_MAIN_G, 1);
    ped_req = 1'b0;
    run_state(S_MAIN_G, 1);
    run_state(S_MAIN_Y, 3);
    run_state(S_CLR1, 2);
    exp_walk = 1'b1;
    run_state(S_SIDE_G, 6);
    exp_walk = 1'b0;
    run_state(S_SIDE_Y, 3);
    run_state(S_CLR2, 2);
    run_state(S_MAIN_G, 20);
`else
    // Pedestrian button has no effect without the crossing feature.
    ped_req = 1'b1;
    run_state(S_MAIN_G, 1);
    ped_req = 1'b0;
    run_state(S_MAIN_G, 40);
`endif

    // Night mode: yellow, clearance, 4-on/4-off flashing, then back via INIT.
    day = 1'b0;
    run_state(S_MAIN_G, 1);
    run_state(S_MAIN_Y, 3);
    run_state(S_CLR1, 2);
    run_night(1'b1, 4);
    run_night(1'b0, 4);
    run_night(1'b1, 4);
    run_night(1'b0, 2);
    day = 1'b1;
    run_night(1'b0, 1);
    run_state(S_INIT, 2);
    run_state(S_MAIN_G, 10);

    // Request after night goes to SIDE_G (night request cleared); reset mid-SIDE_G.
    side_req = 1'b1;
    run_state(S_MAIN_G, 1);
    side_req = 1'b0;
    run_state(S_MAIN_G, 1);
    run_state(S_MAIN_Y, 3);
    run_state(S_CLR1, 2);
    run_state(S_SIDE_G, 2);
    side_req = 1'b1;
    ped_req  = 1'b1;
    run_state(S_SIDE_G, 1);
    side_req = 1'b0;
    ped_req  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_state", 8'(state_o), 8'(S_INIT));
    check("async_rst_lamps", 8'(lamps), 8'(6'b100_100));
    check("async_rst_walk", 8'(ped_walk), 8'd0);
    step();
    reset = 1'b0;
    run_state(S_INIT, 2);
    run_state(S_MAIN_G, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
